// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package fetch_pkg;

  localparam int DEF_XLEN = 32;
  localparam logic [DEF_XLEN-1:0] DEF_RESET_PC = 32'h8000_0000;
  localparam int ILEN_BYTES = 4;

  typedef struct packed {
    logic [31:0]         inst;
    logic [DEF_XLEN-1:0] pc;
    logic                err;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO of fetch entries with flush.
// Head is read straight from the entry registers (no bypass).
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  push_data_i,
  input  logic          pop_i,
  output fetch_entry_t  head_o,
  output logic          head_valid_o,
  output logic [CW-1:0] count_o
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  logic         full;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign count_o      = wr_ptr_q - rd_ptr_q;
  assign full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_valid_o = (count_o != '0);
  assign head_o       = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data_i;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_i && head_valid_o) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(push_i && full && !flush_i))
        else $error("fetch_fifo: push while full");
    end
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Free-running fetch front end: credit-limited requests, prefetch
// queue toward Decode, and redirect flushing of queue and in-flight data.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN            = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC        = DEF_RESET_PC,
  parameter int              QUEUE_DEPTH     = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            enable_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            mem_req_valid_o,
  output logic [XLEN-1:0] mem_req_addr_o,
  input  logic            mem_req_ready_i,
  input  logic            mem_rsp_valid_i,
  input  logic [31:0]     mem_rsp_data_i,
  input  logic            mem_rsp_err_i,
  output logic            inst_valid_o,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic            inst_err_o,
  input  logic            inst_ready_i
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0]   MAX_C   = CW'(MAX_OUTSTANDING);
  localparam logic [CW:0]     DEPTH_C = (CW+1)'(QUEUE_DEPTH);
  localparam logic [CW-1:0]   ONE     = CW'(1);
  localparam logic [XLEN-1:0] STEP    = XLEN'(ILEN_BYTES);
  localparam logic [XLEN-1:0] ALIGN   = ~XLEN'(ILEN_BYTES - 1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic            halted_q, halted_d;
  logic            req_valid_q, req_valid_d;

  logic            fire;
  logic            push;
  logic            pop;
  logic            credit_ok;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_d;
  logic [CW:0]     credit_sum;
  logic            head_valid;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // A redirect withdraws the request in the same cycle it arrives.
  assign mem_req_valid_o = req_valid_q && !redirect_i;
  assign mem_req_addr_o  = fetch_pc_q;

  assign fire = mem_req_valid_o && mem_req_ready_i;
  assign pop  = head_valid && inst_ready_i && !redirect_i;
  assign push = mem_rsp_valid_i && !redirect_i && (drop_q == '0);

  always_comb begin
    push_entry.inst = mem_rsp_err_i ? 32'h0 : mem_rsp_data_i;
    push_entry.pc   = rsp_pc_q;
    push_entry.err  = mem_rsp_err_i;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_d      = out_q + CW'(fire) - CW'(mem_rsp_valid_i);
    drop_d     = drop_q;
    halted_d   = halted_q;
    count_d    = count + CW'(push) - CW'(pop);

    if (fire) begin
      fetch_pc_d = fetch_pc_q + STEP;
    end
    if (mem_rsp_valid_i && (drop_q != '0)) begin
      drop_d = drop_q - ONE;
    end
    if (push) begin
      rsp_pc_d = rsp_pc_q + STEP;
      if (mem_rsp_err_i) begin
        halted_d = 1'b1;
      end
    end

    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & ALIGN;
      rsp_pc_d   = redirect_pc_i & ALIGN;
      halted_d   = 1'b0;
      drop_d     = out_q - CW'(mem_rsp_valid_i);
      count_d    = '0;
    end

    // Credits are judged on next-state values so the registered
    // request never overcommits the queue.
    credit_sum = {1'b0, count_d} + {1'b0, out_d};
    credit_ok  = (out_d < MAX_C) && (credit_sum < DEPTH_C);

    if (req_valid_q && !fire && !redirect_i) begin
      req_valid_d = 1'b1;
    end else begin
      req_valid_d = enable_i && !halted_d && credit_ok;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q  <= RESET_PC;
      rsp_pc_q    <= RESET_PC;
      out_q       <= '0;
      drop_q      <= '0;
      halted_q    <= 1'b0;
      req_valid_q <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      rsp_pc_q    <= rsp_pc_d;
      out_q       <= out_d;
      drop_q      <= drop_d;
      halted_q    <= halted_d;
      req_valid_q <= req_valid_d;
    end
  end

  fetch_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (redirect_i),
    .push_i       (push),
    .push_data_i  (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .head_valid_o (head_valid),
    .count_o      (count)
  );

  assign inst_valid_o = head_valid;
  assign inst_o       = head.inst;
  assign inst_pc_o    = head.pc;
  assign inst_err_o   = head.err;

endmodule
